// File: rtl/bus_receiver_pkg.sv
// Shared width definitions for the tristate data bus. The tristate driver
// imports the same package, so both ends of the bus agree on width.
package bus_receiver_pkg;

  localparam int BUS_WIDTH  = 16;
  localparam int FIFO_DEPTH = 4;

endpackage : bus_receiver_pkg

// File: rtl/bus_fifo_mem.sv
// DEPTH x WIDTH register array for the bus receiver.
// It has one synchronous write port and one asynchronous read port.
module bus_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the
  // occupancy count, and leaving it unreset lets it map onto plain registers or RAM.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : bus_fifo_mem

// File: rtl/bus_receiver.sv
// Capture-side endpoint of the shared tristate bus. Words strobed by load
// are queued in a small FIFO and handed to a valid/ready consumer.
module bus_receiver
  import bus_receiver_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           bus,
  input  logic                       load,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clear_overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [WIDTH-1:0] head;
  logic             push, pop, drop;

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A pop on a full FIFO frees the slot the push needs in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = load && (!full || pop);
  assign drop = load && full && !pop;

  bus_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)                overflow_q <= 1'b1;
      else if (clear_overflow) overflow_q <= 1'b0;
    end
  end

  // NOTE: the default assignment comes first so no path through the block
  // leaves out_data unassigned, which would infer a latch.
  always_comb begin
    out_data = '0;
    if (out_valid) out_data = head;
  end

endmodule : bus_receiver

// File: doc/bus_receiver.md
# bus_receiver

Capture-side endpoint of the shared 16-bit tristate data bus. Samples the bus on cycles when a driver has been granted (`load` high), queues captured words in a small FIFO, and presents them to a consumer over a valid/ready handshake. The bus-side producer never stalls; overflow is dropped and flagged.

## Interface

- `WIDTH`, 16, bus and data width in bits.
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bus`  in  WIDTH  shared tristate bus; valid only when `load` = 1.
- `load`  in  1  capture strobe, asserted in the cycle a driver enables onto `bus`.
- `out_data`  out  WIDTH  head-of-FIFO word.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `full`  out  1  `count` == DEPTH.
- `overflow`  out  1  sticky: a `load` was dropped.
- `clear_overflow`  in  1  clears `overflow`.

## Operation

- Reset (async assert, sync release): `count` = 0, read/write pointers = 0, `out_valid` = 0, `out_data` = 0, `full` = 0, `overflow` = 0. Storage contents are don't-care. Reset mid-transfer discards all queued words.
- Push: `load` && (!`full` || pop) writes `bus` at the write pointer, then increments the write pointer modulo DEPTH.
- Pop: `out_valid` && `out_ready` increments the read pointer modulo DEPTH.
- Simultaneous push and pop:
  - `count` is unchanged.
  - If full, the push is still accepted, because the pop frees the slot the same cycle.
  - If empty, no pop occurs (`out_valid` = 0) and the push proceeds normally.
- Drop: `load` && `full` && !pop leaves storage and pointers untouched and sets `overflow` = 1.
- `overflow`:
  - `clear_overflow` clears it.
  - If a drop and `clear_overflow` occur in the same cycle, set wins.
- `count`:
  - +1 on push only, −1 on pop only.
  - Never exceeds DEPTH and never underflows.
- `out_valid` = (`count` != 0).
- `out_data`:
  - Equals storage[read pointer] when `out_valid`.
  - Equals 0 when empty; no bus X/Z ever reaches the output.
- `bus` is ignored whenever `load` = 0. Floating bus values on idle cycles must not affect state.
- Pointer wrap-around is silent; occupancy is tracked only by `count`.
- Word order is strictly FIFO.

## Timing

- Capture: `bus` is sampled at the rising edge that ends the `load` cycle.
- Latency: the word appears on `out_data` with `out_valid` = 1 in the cycle after capture when the FIFO was empty. There is no combinational path from `bus` to `out_data`.
- `count`, `full`, and `overflow` update at the same edge as the push/pop that changes them.
- `out_ready` may be high while `out_valid` = 0; it has no effect then.
- `out_valid` must not depend combinationally on `out_ready`.
- Throughput: one push and one pop per cycle, sustained.

## Structure

- Shared package/header holds `BUS_WIDTH` = 16. It is shared with the tristate driver so that both ends agree on width.
- Sub-module `bus_fifo_mem`: DEPTH×WIDTH register array with one synchronous write port and one asynchronous read port. Pointers, count, and flags stay in `bus_receiver`.

## Test plan

- Reset, then `load` = 1 with `bus` = 16'hA5A5 for one cycle -> next cycle `out_valid` = 1, `out_data` = 16'hA5A5, `count` = 1. Then `out_ready` = 1 for one cycle -> `count` = 0, `out_valid` = 0, `out_data` = 0.
- With `out_ready` = 0, load 16'h0001..16'h0005 on five consecutive cycles -> `full` = 1 after the 4th. The 5th word is dropped and `overflow` = 1. Draining yields 0001, 0002, 0003, 0004 in order.
- Full FIFO, `load` (16'h00FF) and `out_ready` high in the same cycle -> `count` stays 4 and `overflow` stays 0. The head pops, and 16'h00FF is the last word out.
- Drive `bus` to 16'hzzzz / 16'hxxxx with `load` = 0 for 10 cycles -> `count`, `out_data`, and the flags are unchanged and free of X.
- Continuous push/pop for 3×DEPTH cycles with an incrementing pattern -> output sequence matches input with no loss, exercising pointer wrap.
- Assert `reset_n` = 0 asynchronously, mid-cycle, with `count` = 3 and `overflow` = 1 -> all outputs go to 0 immediately, without waiting for a clock edge. After release, the first captured word appears correctly.
